// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Purpose:
//   Accumulator-side controller for the 8-bit alu. It accepts one instruction
//   at a time over a valid/ready handshake and drives the ALU operand and
//   opcode inputs. The ALU result is written back into an 8-bit accumulator
//   for (count + 1) iterations. A load instruction writes the operand straight
//   into the accumulator in a single cycle and leaves the ALU inputs at zero.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   instr_valid    in   instruction present
//   instr_ready    out  sequencer can accept an instruction (registered)
//   instr_op       in   [3:0] ALU opcode to issue
//   instr_operand  in   [7:0] B operand, or load value
//   instr_count    in   [2:0] repeat count (iterations = count + 1)
//   instr_load     in   1 = load operand into accumulator, bypassing the ALU
//   alu_a          out  [7:0] to ALU A (accumulator while issuing, else 0)
//   alu_b          out  [7:0] to ALU B (latched operand while issuing, else 0)
//   alu_opcode     out  [3:0] to ALU opcode (latched op while issuing, else CLR)
//   alu_y          in   [7:0] from ALU Y
//   acc            out  [7:0] accumulator value
//   done           out  one-cycle completion pulse (registered)
//   zero           out  accumulator-is-zero flag
//
// Configuration:
//   ALU_SEQ_ZERO_FLAG_EN  defined   : zero is a register tracking (acc == 0),
//                                     reset value 1.
//                         undefined : zero is tied to 0, no flag register.
//
// States:
//   state  | meaning
//   IDLE   | instr_ready = 1, waiting for a handshake
//   EXEC   | issuing one ALU operation (or the load) per cycle
//   DONE   | done = 1 for exactly one cycle, accumulator final
// -----------------------------------------------------------------------------

`timescale 1ns/1ps

module alu_op_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [7:0] instr_operand,
    input  logic [2:0] instr_count,
    input  logic       instr_load,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_opcode,
    input  logic [7:0] alu_y,
    output logic [7:0] acc,
    output logic       done,
    output logic       zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_done;
    logic        r_issue;     // EXEC of a non-load instruction: ALU inputs live
    logic        r_load;
    logic [3:0]  r_op;
    logic [7:0]  r_operand;
    logic [2:0]  r_count;     // iterations remaining after the current one
    logic [7:0]  r_acc;

    logic [7:0]  w_acc_next;

    assign w_acc_next = r_load ? r_operand : alu_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_issue   <= 1'b0;
            r_load    <= 1'b0;
            r_op      <= 4'b0000;
            r_operand <= 8'h00;
            r_count   <= 3'd0;
            r_acc     <= 8'h00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (instr_valid && r_ready) begin
                        r_state   <= S_EXEC;
                        r_ready   <= 1'b0;
                        r_load    <= instr_load;
                        r_op      <= instr_op;
                        r_operand <= instr_operand;
                        // A load is always exactly one EXEC cycle.
                        r_count   <= instr_load ? 3'd0 : instr_count;
                        r_issue   <= ~instr_load;
                    end
                end
                S_EXEC: begin
                    r_acc <= w_acc_next;
                    if (r_count == 3'd0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_issue <= 1'b0;
                        r_load  <= 1'b0;
                    end else begin
                        r_count <= r_count - 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_issue <= 1'b0;
                    r_load  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic r_zero;

    // Follows every accumulator write so it always matches acc == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b1;
        end else if (r_state == S_EXEC) begin
            r_zero <= (w_acc_next == 8'h00);
        end
    end

    assign zero = r_zero;
`else
    assign zero = 1'b0;
`endif

    // ALU inputs are gated decodes of registered state; CLR with zero operands
    // whenever nothing is being issued.
    assign alu_a       = r_issue ? r_acc     : 8'h00;
    assign alu_b       = r_issue ? r_operand : 8'h00;
    assign alu_opcode  = r_issue ? r_op      : 4'b0000;

    assign instr_ready = r_ready;
    assign done        = r_done;
    assign acc         = r_acc;

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps

module tb_alu_op_sequencer;

    localparam logic [3:0] OP_CLR = 4'b0000;
    localparam logic [3:0] OP_ROL = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1100;
    localparam logic [3:0] OP_AND = 4'b1111;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [7:0] instr_operand;
    logic [2:0] instr_count;
    logic       instr_load;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_y;
    logic [7:0] acc;
    logic       done;
    logic       zero;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] acc;
        logic       z;
        int         cyc;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_acc;

    alu_op_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_operand (instr_operand),
        .instr_count   (instr_count),
        .instr_load    (instr_load),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_opcode    (alu_opcode),
        .alu_y         (alu_y),
        .acc           (acc),
        .done          (done),
        .zero          (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the alu, covering the key-independent opcodes only.
    always_comb begin
        alu_y = 8'h00;
        case (alu_opcode)
            OP_ROL:  alu_y = {alu_a[6:0], alu_a[7]};
            OP_SHL:  alu_y = {alu_a[6:0], 1'b0};
            OP_SUB:  alu_y = alu_a - alu_b;
            OP_AND:  alu_y = alu_a & alu_b;
            default: alu_y = 8'h00;
        endcase
    end

    function automatic logic zexp(input logic [7:0] a);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        return (a == 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    // Closed-form result of applying an opcode n times to the accumulator.
    function automatic logic [7:0] ref_result(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] op, input int n);
        logic [15:0] wide;
        int          r;
        case (op)
            OP_ROL: begin
                r    = n % 8;
                wide = {a, a} << r;
                return wide[15:8];
            end
            OP_SHL: begin
                wide = {8'h00, a} << n;
                return wide[7:0];
            end
            OP_SUB:  return 8'((int'(a) - n * int'(b)) & 255);
            OP_AND:  return a & b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Presents an instruction (held until the handshake), pushes the expected
    // completion into the scoreboard, and returns at the negedge after accept.
    task automatic issue(input logic [3:0] op, input logic [7:0] opnd, input logic [2:0] cnt,
                         input logic ld, output int acc_cyc, output int waited);
        int         n;
        logic [7:0] a;
        exp_t       e;
        instr_valid   = 1'b1;
        instr_op      = op;
        instr_operand = opnd;
        instr_count   = cnt;
        instr_load    = ld;
        waited        = 0;
        while (instr_ready !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (instr_ready !== 1'b1) begin
            chk("handshake_timeout", instr_ready, 1);
            instr_valid = 1'b0;
            acc_cyc     = -1;
            return;
        end
        acc_cyc = cyc + 1;
        n       = ld ? 1 : int'(cnt) + 1;
        a       = ld ? opnd : ref_result(m_acc, opnd, op, n);
        m_acc   = a;
        e.acc   = a;
        e.z     = zexp(a);
        e.cyc   = acc_cyc + n;
        sb_q.push_back(e);
        @(negedge clk);
        instr_valid   = 1'b0;
        instr_op      = 4'($urandom_range(0, 15));
        instr_operand = 8'($urandom_range(0, 255));
        instr_count   = 3'($urandom_range(0, 7));
        instr_load    = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_timeout", sb_q.size(), 0);
    endtask

    // Monitor: every done pulse must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("acc_at_done", acc, e.acc);
                    chk("zero_at_done", zero, e.z);
                    chk("done_cycle", cyc, e.cyc);
                    chk("ready_in_done", instr_ready, 0);
                    chk("opcode_in_done", alu_opcode, 0);
                end
            end
        end
    end

    initial begin
        int         ca, cb, wa, wb, ndone;
        logic [7:0] rol_seq [3];
        logic [3:0] ops [5];

        rol_seq[0] = 8'h03;
        rol_seq[1] = 8'h06;
        rol_seq[2] = 8'h0C;
        ops[0] = OP_CLR; ops[1] = OP_ROL; ops[2] = OP_SHL; ops[3] = OP_SUB; ops[4] = OP_AND;

        rst           = 1'b1;
        instr_valid   = 1'b0;
        instr_op      = 4'b0000;
        instr_operand = 8'h00;
        instr_count   = 3'd0;
        instr_load    = 1'b0;
        m_acc         = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_acc", acc, 8'h00);
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_opcode", alu_opcode, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_zero", zero, zexp(8'h00));
        rst = 1'b0;
        @(negedge clk);

        // Load 0x81 then ROL x3.
        issue(1'b0 ? OP_CLR : OP_CLR, 8'h81, 3'd5, 1'b1, ca, wa);
        issue(OP_ROL, 8'h00, 3'd2, 1'b0, ca, wa);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rol_seq", acc, rol_seq[i]);
        end
        drain();

        // SUB 0x0D from 0x0C.
        issue(OP_SUB, 8'h0D, 3'd0, 1'b0, ca, wa);
        drain();
        chk("sub_acc", acc, 8'hFF);
        chk("sub_zero", zero, 0);

        // AND with 0x00.
        issue(OP_AND, 8'h00, 3'd0, 1'b0, ca, wa);
        drain();
        chk("and_acc", acc, 8'h00);
        chk("and_zero", zero, zexp(8'h00));

        // Second instruction held valid while the first executes (N = 4).
        issue(OP_CLR, 8'h40, 3'd0, 1'b1, ca, wa);
        drain();
        issue(OP_SUB, 8'h01, 3'd3, 1'b0, ca, wa);
        issue(OP_SHL, 8'h00, 3'd1, 1'b0, cb, wb);
        chk("hold_wait_cycles", wb, 5);
        chk("hold_accept_cycle", cb, ca + 6);
        drain();
        chk("hold_acc", acc, 8'hF0);

        // Reset in the middle of a long SHL.
        issue(OP_CLR, 8'h01, 3'd0, 1'b1, ca, wa);
        drain();
        issue(OP_SHL, 8'h00, 3'd7, 1'b0, ca, wa);
        repeat (3) @(negedge clk);
        chk("shl_before_rst", acc, 8'h08);
        #1;
        rst = 1'b1;
        sb_q.delete();
        m_acc = 8'h00;
        #1;
        chk("abort_acc", acc, 8'h00);
        chk("abort_ready", instr_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_opcode", alu_opcode, 0);
        chk("abort_zero", zero, zexp(8'h00));
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_idle_ready", instr_ready, 1);

        // Randomized instruction stream.
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic       ld;
            op = ops[$urandom_range(0, 4)];
            ld = ($urandom_range(0, 3) == 0);
            issue(op, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), ld, ca, wa);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        chk("final_acc", acc, m_acc);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        n_err++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $fatal(1, "timeout");
    end

endmodule
